imm_narrow_serializer: RTL and testbench

Encode-side counterpart of the 8-to-16 sign extender. The block accepts 16-bit constants and emits them as 8-bit immediate bytes for the instruction/immediate stream.
- If the value is exactly reproducible by sign-extending its low byte, it emits one SHORT byte.
- Otherwise it emits a HIGH byte followed by a LOW byte.
- Valid/ready handshakes on both sides.
- Running counters of short and long encodings for toolchain/debug visibility.

---
 rtl/imm_narrow_serializer.sv | 128 ++++++++++++
 tb/tb_imm_narrow_serializer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_narrow_serializer.sv
// imm_narrow_serializer
// Encodes 16-bit constants as 8-bit immediate bytes. A value that equals the
// sign extension of its low byte goes out as one SHORT byte. Any other value
// goes out as a HIGH byte followed by a LOW byte. Counters record how many
// values took each encoding.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready depends only on state. out_valid, out_byte, out_kind and
// out_last come from registers or state. Nothing combinational runs from
// in_* or out_ready to any output. While out_valid && !out_ready, the
// presented byte stays stable and the FSM holds.
//
// IN_W must equal 2*OUT_W.
module imm_narrow_serializer #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_byte,
    output logic [1:0]       out_kind,
    output logic             out_last,
    output logic [CNT_W-1:0] short_cnt,
    output logic [CNT_W-1:0] long_cnt
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EMIT_SHORT = 2'd1,
        EMIT_HI    = 2'd2,
        EMIT_LO    = 2'd3
    } state_t;

    localparam logic [1:0] KIND_SHORT = 2'b00;
    localparam logic [1:0] KIND_HIGH  = 2'b01;
    localparam logic [1:0] KIND_LOW   = 2'b10;

    state_t          state;
    state_t          state_nxt;
    logic [IN_W-1:0] hold;
    logic [1:0]      kind_q;
    logic            last_q;
    logic            accept;
    logic            fits;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state != IDLE);
    assign accept    = in_valid && in_ready;

    // The top IN_W-OUT_W+1 bits must be all equal. Then the low byte's sign
    // bit reproduces every upper bit.
    assign fits = (&in_value[IN_W-1:OUT_W-1]) || (~|in_value[IN_W-1:OUT_W-1]);

    // In EMIT_HI the byte is the high half of the held value. Every other
    // state shows the low half. This keeps the last SHORT/LOW byte visible
    // after the return to IDLE, and the byte reads 0 after reset.
    assign out_byte = (state == EMIT_HI) ? hold[IN_W-1:OUT_W] : hold[OUT_W-1:0];
    assign out_kind = kind_q;
    assign out_last = last_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, advance only when the byte is taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = fits ? EMIT_SHORT : EMIT_HI;
                end
            end
            EMIT_SHORT: begin
                if (out_ready) state_nxt = IDLE;
            end
            EMIT_HI: begin
                if (out_ready) state_nxt = EMIT_LO;
            end
            EMIT_LO: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding register and kind/last flags, loaded on accept and on HI->LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold   <= '0;
            kind_q <= KIND_SHORT;
            last_q <= 1'b0;
        end else if (accept) begin
            hold   <= in_value;
            kind_q <= fits ? KIND_SHORT : KIND_HIGH;
            last_q <= fits;
        end else if (state == EMIT_HI && out_ready) begin
            kind_q <= KIND_LOW;
            last_q <= 1'b1;
        end
    end

    // Encoding statistics, bumped on the accept edge, wrapping on overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_cnt <= '0;
            long_cnt  <= '0;
        end else if (accept) begin
            if (fits) begin
                short_cnt <= short_cnt + 1'b1;
            end else begin
                long_cnt <= long_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_narrow_serializer.sv
// Testbench for imm_narrow_serializer: directed scenarios plus a random run
// checked against the decode property.
module tb_imm_narrow_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [1:0]  out_kind;
    logic        out_last;
    logic [15:0] short_cnt;
    logic [15:0] long_cnt;

    int tests;
    int fails;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [7:0]  byte_q[$];
    logic [1:0]  kind_q[$];
    logic [7:0]  hi_byte;
    logic        ready_rand;

    imm_narrow_serializer #(.IN_W(16), .OUT_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_kind  (out_kind),
        .out_last  (out_last),
        .short_cnt (short_cnt),
        .long_cnt  (long_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- consumer monitor ----------------
    // Records every output handshake and rebuilds the values it encodes.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            byte_q.push_back(out_byte);
            kind_q.push_back(out_kind);
            case (out_kind)
                2'b00: got_q.push_back({{8{out_byte[7]}}, out_byte});
                2'b01: hi_byte = out_byte;
                2'b10: got_q.push_back({hi_byte, out_byte});
                default: got_q.push_back(16'hxxxx);
            endcase
        end
    end

    // Random consumer backpressure, active only while ready_rand is set
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    // Presents v with in_valid high until it is accepted. in_valid is left high.
    task automatic drive_value(input logic [15:0] v);
        int n;
        in_valid = 1'b1;
        in_value = v;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL accept_timeout: in_ready stuck at %b, required 1 (value %h)", in_ready, v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(in_ready && !out_valid) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (!(in_ready && !out_valid)) begin
            fails++;
            $display("FAIL drain_timeout: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic clear_monitor();
        got_q.delete();
        byte_q.delete();
        kind_q.delete();
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_value = '0; out_ready = 1'b0; ready_rand = 1'b0;
        #12;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        tests++; if (out_byte !== 8'h00) begin fails++; $display("FAIL rst_out_byte: got %h required 00", out_byte); end
        tests++; if (out_kind !== 2'b00) begin fails++; $display("FAIL rst_out_kind: got %b required 00", out_kind); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last: got %b required 0", out_last); end
        tests++; if (short_cnt !== 16'd0 || long_cnt !== 16'd0) begin fails++; $display("FAIL rst_counters: got %0d/%0d required 0/0", short_cnt, long_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_short();
        logic [15:0] vals [2];
        logic [7:0]  bytes [2];
        vals = '{16'hFFF0, 16'h000F};
        bytes = '{8'hF0, 8'h0F};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_value(vals[i]);
            in_valid = 1'b0;
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL short_valid[%0d]: got %b required 1", i, out_valid); end
            tests++; if (out_byte !== bytes[i]) begin fails++; $display("FAIL short_byte[%0d]: got %h required %h", i, out_byte, bytes[i]); end
            tests++; if (out_kind !== 2'b00 || out_last !== 1'b1) begin fails++; $display("FAIL short_kind_last[%0d]: got %b/%b required 00/1", i, out_kind, out_last); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL short_in_ready_busy[%0d]: got %b required 0", i, in_ready); end
            tests++; if (short_cnt !== 16'(i + 1)) begin fails++; $display("FAIL short_cnt[%0d]: got %0d required %0d", i, short_cnt, i + 1); end
            @(posedge clk);
            #1;
            tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL short_return[%0d]: valid/ready got %b/%b required 0/1", i, out_valid, in_ready); end
            tests++; if (out_byte !== bytes[i] || out_kind !== 2'b00 || out_last !== 1'b1) begin fails++; $display("FAIL short_hold_after[%0d]: got %h/%b/%b required %h/00/1", i, out_byte, out_kind, out_last, bytes[i]); end
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] vals [4];
        logic [7:0]  b0 [4];
        logic [7:0]  b1 [4];
        logic [1:0]  k0 [4];
        vals = '{16'h007F, 16'hFF80, 16'h0080, 16'hFF7F};
        b0   = '{8'h7F, 8'h80, 8'h00, 8'hFF};
        k0   = '{2'b00, 2'b00, 2'b01, 2'b01};
        b1   = '{8'h00, 8'h00, 8'h80, 8'h7F};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_value(vals[i]);
            in_valid = 1'b0;
            tests++; if (out_valid !== 1'b1 || out_byte !== b0[i] || out_kind !== k0[i]) begin fails++; $display("FAIL bound_first[%0d]: got v=%b %h/%b required 1 %h/%b", i, out_valid, out_byte, out_kind, b0[i], k0[i]); end
            tests++; if (out_last !== (k0[i] == 2'b00)) begin fails++; $display("FAIL bound_first_last[%0d]: got %b", i, out_last); end
            if (k0[i] == 2'b01) begin
                @(posedge clk);
                #1;
                tests++; if (out_valid !== 1'b1 || out_byte !== b1[i] || out_kind !== 2'b10 || out_last !== 1'b1) begin fails++; $display("FAIL bound_low[%0d]: got v=%b %h/%b/%b required 1 %h/10/1", i, out_valid, out_byte, out_kind, out_last, b1[i]); end
            end
            @(posedge clk);
            #1;
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bound_done[%0d]: out_valid got %b required 0", i, out_valid); end
        end
        tests++; if (short_cnt !== 16'd4 || long_cnt !== 16'd2) begin fails++; $display("FAIL bound_counters: got %0d/%0d required 4/2", short_cnt, long_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_value(16'h1234);
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tests++; if (out_valid !== 1'b1 || out_byte !== 8'h12 || out_kind !== 2'b01 || out_last !== 1'b0) begin fails++; $display("FAIL bp_stall[%0d]: got v=%b %h/%b/%b required 1 12/01/0", c, out_valid, out_byte, out_kind, out_last); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b required 0", c, in_ready); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b1 || out_byte !== 8'h34 || out_kind !== 2'b10 || out_last !== 1'b1) begin fails++; $display("FAIL bp_low: got v=%b %h/%b/%b required 1 34/10/1", out_valid, out_byte, out_kind, out_last); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_low_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: ready/valid got %b/%b required 1/0", in_ready, out_valid); end
        tests++; if (long_cnt !== 16'd3) begin fails++; $display("FAIL bp_long_cnt: got %0d required 3", long_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] eb [3];
        logic [1:0] ek [3];
        eb = '{8'hAB, 8'hCD, 8'h05};
        ek = '{2'b01, 2'b10, 2'b00};
        clear_monitor();
        out_ready = 1'b1;
        drive_value(16'hABCD);
        drive_value(16'h0005);
        in_valid = 1'b0;
        wait_drain();
        tests++; if (byte_q.size() != 3) begin fails++; $display("FAIL b2b_count: got %0d bytes required 3", byte_q.size()); end
        for (int i = 0; i < 3 && i < byte_q.size(); i++) begin
            tests++; if (byte_q[i] !== eb[i] || kind_q[i] !== ek[i]) begin fails++; $display("FAIL b2b_byte[%0d]: got %h/%b required %h/%b", i, byte_q[i], kind_q[i], eb[i], ek[i]); end
        end
        tests++; if (short_cnt !== 16'd5 || long_cnt !== 16'd4) begin fails++; $display("FAIL b2b_counters: got %0d/%0d required 5/4", short_cnt, long_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_value(16'h4000);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_byte !== 8'h40 || out_kind !== 2'b01) begin fails++; $display("FAIL rmid_pre: got v=%b %h/%b required 1 40/01", out_valid, out_byte, out_kind); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rmid_async: valid/ready got %b/%b required 0/1", out_valid, in_ready); end
        tests++; if (out_byte !== 8'h00 || out_kind !== 2'b00 || out_last !== 1'b0) begin fails++; $display("FAIL rmid_outputs: got %h/%b/%b required 00/00/0", out_byte, out_kind, out_last); end
        tests++; if (short_cnt !== 16'd0 || long_cnt !== 16'd0) begin fails++; $display("FAIL rmid_counters: got %0d/%0d required 0/0", short_cnt, long_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_monitor();
        out_ready = 1'b1;
        drive_value(16'hFFFF);
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_byte !== 8'hFF || out_kind !== 2'b00 || out_last !== 1'b1) begin fails++; $display("FAIL rmid_after: got v=%b %h/%b/%b required 1 FF/00/1", out_valid, out_byte, out_kind, out_last); end
        tests++; if (short_cnt !== 16'd1 || long_cnt !== 16'd0) begin fails++; $display("FAIL rmid_after_cnt: got %0d/%0d required 1/0", short_cnt, long_cnt); end
        wait_drain();
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [7:0]  b;
        int n_short;
        int n_long;
        n_short = 0;
        n_long = 0;
        clear_monitor();
        ready_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom_range(0, 255));
                v = {{8{b[7]}}, b};
            end else begin
                v = 16'($urandom_range(0, 65535));
            end
            if (v[15:7] == 9'h000 || v[15:7] == 9'h1FF) n_short++;
            else n_long++;
            exp_q.push_back(v);
            drive_value(v);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        ready_rand = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();
        tests++; if (got_q.size() != 1000) begin fails++; $display("FAIL rand_count: got %0d values required 1000", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_value[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        tests++; if (short_cnt !== 16'(1 + n_short) || long_cnt !== 16'(n_long)) begin fails++; $display("FAIL rand_counters: got %0d/%0d required %0d/%0d", short_cnt, long_cnt, 1 + n_short, n_long); end
        tests++; if (32'(short_cnt) + 32'(long_cnt) !== 32'd1001) begin fails++; $display("FAIL rand_cnt_sum: got %0d required 1001", 32'(short_cnt) + 32'(long_cnt)); end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_short();
        test_boundaries();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
